// File: rtl/demux5_8b_stream_pkg.sv
// Shared constants for the 1-to-5 8-bit stream distributor.
package demux5_8b_stream_pkg;

    localparam int unsigned W     = 8;   // data width per beat
    localparam int unsigned N     = 5;   // number of output channels
    localparam int unsigned SEL_W = 3;   // select width, 2**SEL_W >= N
    localparam int unsigned CNT_W = 8;   // dropped-beat counter width

    // Number of select codes, legal or not.
    localparam int unsigned SEL_SPAN = 1 << SEL_W;

    // Saturation value of the dropped-beat counter.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/demux5_8b_stream_if.sv
// Stream bundle for demux5_8b_stream.
//   in_valid/in_ready/in_data/in_sel : single producer side
//   out_valid/out_ready/out_data     : N consumer channels, channel i at out_data[i*W +: W]
// slave  : the distributor's view
// master : the producer/consumer environment's view
interface demux5_8b_stream_if;
    import demux5_8b_stream_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic [SEL_W-1:0]   in_sel;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic [N*W-1:0]     out_data;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux5_8b_stream_slot.sv
// One-entry valid/ready holding register for a single output channel.
//   load/load_data : write a beat (caller only loads when free)
//   pop            : consumer ready; takes the beat when valid
//   valid/data     : registered channel output
//   free           : slot can accept a load this cycle (empty or popping)
module demux_slot
    import demux5_8b_stream_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    assign free = ~valid | pop;

    // Load wins over pop so a same-cycle pop+load keeps the slot full.
    // Data only changes on load, so it holds while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux5_8b_stream.sv
// Registered 1-to-N distributor for W-bit beats. Each beat goes to the channel
// named by in_sel; beats with an out-of-range select are accepted and dropped,
// counted by a saturating counter and flagged by a one-cycle pulse.
//   clk, reset : clock, async active-high reset
//   bus        : stream bundle (slave modport)
//   drop_cnt   : saturating count of dropped beats
//   drop_pulse : a beat was dropped on the previous edge
module demux5_8b_stream
    import demux5_8b_stream_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    demux5_8b_stream_if.slave   bus,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                drop_pulse
);

    logic [N-1:0]        free;
    logic [N-1:0]        load;
    logic [SEL_SPAN-1:0] free_pad;
    logic                legal;
    logic                accept;
    logic                drop;

    // Widen the free vector so any select code can index it safely.
    assign free_pad = SEL_SPAN'(free);
    assign legal    = {1'b0, bus.in_sel} < (SEL_W+1)'(N);

    // Illegal selects are always accepted so they cannot stall the producer.
    assign bus.in_ready = legal ? free_pad[bus.in_sel] : 1'b1;
    assign accept       = bus.in_valid & bus.in_ready;
    assign drop         = accept & ~legal;

    // One-hot load vector gated by accept.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < N; i++) begin
            load[i] = accept & legal & (bus.in_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[g]),
            .load_data (bus.in_data),
            .pop       (bus.out_ready[g]),
            .valid     (bus.out_valid[g]),
            .data      (bus.out_data[g*W +: W]),
            .free      (free[g])
        );
    end

    // Dropped-beat counter (saturating) and pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux5_8b_stream.sv
module tb_demux5_8b_stream;
    import demux5_8b_stream_pkg::*;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] drop_cnt;
    logic             drop_pulse;
    int               n_cmp;
    int               n_err;

    demux5_8b_stream_if bus ();

    demux5_8b_stream dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .drop_cnt   (drop_cnt),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ch(input int i);
        logic [N*W-1:0] v;
        v = bus.out_data;
        return v[i*W +: W];
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = '0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        chk("rst_drop_pulse", 64'(drop_pulse), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single beat to ch2, then backpressure and pop+load
        bus.in_sel = 3'd2; bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        #1 chk("t1_ready_empty", 64'(bus.in_ready), 64'h1);
        tick();
        chk("t1_valid", 64'(bus.out_valid), 64'h04);
        chk("t1_data", 64'(ch(2)), 64'hA5);
        bus.in_data = 8'h5A;
        #1 chk("t1_ready_full", 64'(bus.in_ready), 64'h0);
        tick();
        chk("t1_hold_valid", 64'(bus.out_valid), 64'h04);
        chk("t1_hold_data", 64'(ch(2)), 64'hA5);
        bus.out_ready = 5'b00100;
        #1 chk("t1_ready_pop", 64'(bus.in_ready), 64'h1);
        tick();
        chk("t1_popload_valid", 64'(bus.out_valid), 64'h04);
        chk("t1_popload_data", 64'(ch(2)), 64'h5A);
        bus.in_valid = 1'b0;
        bus.out_ready = 5'b11111;
        tick();
        chk("t1_drain", 64'(bus.out_valid), 64'h0);
        chk("t1_data_kept", 64'(ch(2)), 64'h5A);

        // Stream one beat per cycle across all channels
        for (int i = 0; i < 5; i++) begin
            bus.in_sel = SEL_W'(i); bus.in_data = 8'h10 + W'(i); bus.in_valid = 1'b1;
            #1 chk("t2_ready", 64'(bus.in_ready), 64'h1);
            tick();
            chk("t2_valid", 64'(bus.out_valid), 64'(1 << i));
            chk("t2_data", 64'(ch(i)), 64'(8'h10 + i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t2_drain", 64'(bus.out_valid), 64'h0);

        // Ch1 blocked, ch3 streams independently
        bus.out_ready = '0;
        bus.in_sel = 3'd1; bus.in_data = 8'h55; bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 5'b01000;
        for (int k = 0; k < 4; k++) begin
            bus.in_sel = 3'd3; bus.in_data = 8'h30 + W'(k);
            #1 chk("t3_ready", 64'(bus.in_ready), 64'h1);
            tick();
            chk("t3_valid", 64'(bus.out_valid), 64'h0A);
            chk("t3_ch1_data", 64'(ch(1)), 64'h55);
            chk("t3_ch3_data", 64'(ch(3)), 64'(8'h30 + k));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 5'b11111;
        tick();
        chk("t3_drain", 64'(bus.out_valid), 64'h0);

        // Illegal selects are dropped and counted
        bus.out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            bus.in_sel = SEL_W'(5 + k); bus.in_data = 8'hEE; bus.in_valid = 1'b1;
            #1 chk("t4_ready", 64'(bus.in_ready), 64'h1);
            tick();
            chk("t4_cnt", 64'(drop_cnt), 64'(k + 1));
            chk("t4_pulse", 64'(drop_pulse), 64'h1);
            chk("t4_valid", 64'(bus.out_valid), 64'h0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t4_pulse_low", 64'(drop_pulse), 64'h0);
        chk("t4_cnt_hold", 64'(drop_cnt), 64'h3);
        bus.in_sel = 3'd7; bus.in_valid = 1'b1;
        repeat (260) tick();
        chk("t4_sat_cnt", 64'(drop_cnt), 64'hFF);
        chk("t4_sat_pulse", 64'(drop_pulse), 64'h1);
        bus.in_valid = 1'b0;
        tick();
        chk("t4_sat_hold", 64'(drop_cnt), 64'hFF);
        chk("t4_sat_pulse_low", 64'(drop_pulse), 64'h0);

        // Asynchronous reset mid-cycle
        bus.in_sel = 3'd4; bus.in_data = 8'hC3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t5_loaded", 64'(ch(4)), 64'hC3);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_valid", 64'(bus.out_valid), 64'h0);
        chk("t5_async_data", 64'(bus.out_data), 64'h0);
        chk("t5_async_cnt", 64'(drop_cnt), 64'h0);
        #2 reset = 1'b0;
        tick();
        bus.in_sel = 3'd4; bus.in_data = 8'h3C; bus.in_valid = 1'b1;
        #1 chk("t5_ready", 64'(bus.in_ready), 64'h1);
        tick();
        chk("t5_valid", 64'(bus.out_valid), 64'h10);
        chk("t5_data", 64'(ch(4)), 64'h3C);
        bus.in_valid = 1'b0;
        bus.out_ready = 5'b11111;
        tick();
        chk("t5_drain", 64'(bus.out_valid), 64'h0);

        // in_valid low: nothing loads, counter idle, data held
        bus.out_ready = '0;
        for (int k = 0; k < 8; k++) begin
            bus.in_sel = SEL_W'(k); bus.in_data = W'($urandom);
            tick();
            chk("t6_valid", 64'(bus.out_valid), 64'h0);
            chk("t6_cnt", 64'(drop_cnt), 64'h0);
            chk("t6_ch4_kept", 64'(ch(4)), 64'h3C);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux5_8b_stream.md
Name: demux5_8b_stream

Overview:
- Registered 1-to-5 distributor for 8-bit beats; the inverse of the team's 5-to-1 8-bit selector.
- Takes one input stream with a per-beat channel select and delivers each beat to exactly one of five output channels.
- Each output channel has its own one-entry holding register with valid/ready handshake.
- Sits between a single producer (e.g. a decode or writeback source) and up to five independent consumers.

Parameters:
W, 8, data width per beat
N, 5, number of output channels (legal range 2..8)
SEL_W, 3, select width; must satisfy 2**SEL_W >= N
CNT_W, 8, width of the dropped-beat counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a beat
in_ready  output  1  block accepts the beat this cycle
in_data  input  W  beat payload
in_sel  input  SEL_W  destination channel index
out_valid  output  N  bit i: channel i holds a beat
out_ready  input  N  bit i: consumer i takes the beat
out_data  output  N*W  channel i data at bits [i*W +: W]
drop_cnt  output  CNT_W  saturating count of beats dropped for illegal select
drop_pulse  output  1  one-cycle registered flag; a beat was dropped last cycle

Behaviour:
- Reset state (asserted asynchronously, held until reset falls):
  - out_valid = 0, out_data = 0, drop_cnt = 0, drop_pulse = 0.
  - Any beat held at reset is discarded.
- Definitions:
  - Channel i is "free" when out_valid[i] = 0 or out_ready[i] = 1 (same-cycle pop frees the slot).
  - Accept = in_valid & in_ready, sampled at the rising edge.
- in_ready is combinational:
  - in_sel < N: in_ready = free(in_sel).
  - in_sel >= N: in_ready = 1; the beat is consumed and dropped.
- Legal accept into channel s:
  - On the next edge, out_valid[s] = 1 and out_data[s] = in_data.
  - Latency is 1 cycle from accept to out_valid.
- Pop of channel i with no load of i: out_valid[i] clears on the next edge. out_data[i] holds its last value; it is don't-care while invalid, but the RTL must not change it.
- Simultaneous pop and load on the same channel: out_valid stays 1 and the new data replaces the old. Full throughput is 1 beat/cycle per channel.
- Channels are independent. Backpressure on channel j never affects acceptance for channel k != j.
- Output stability: while out_valid[i] = 1 and out_ready[i] = 0, out_data[i] and out_valid[i] hold stable.
- Illegal select accept:
  - drop_cnt increments by 1, saturating at 2**CNT_W - 1 with no wrap.
  - drop_pulse = 1 for exactly the next cycle. Back-to-back drops keep drop_pulse high.
- in_valid = 0: no state change except pops. in_sel and in_data are ignored.
- Path rules:
  - No combinational path from in_data to out_data.
  - The only combinational path is out_ready/in_sel -> in_ready.

Decomposition:
- Shared package holds:
  - Constants W = 8, N = 5, SEL_W = 3, CNT_W = 8.
  - A localparam for the saturation value.
- Natural sub-module: demux_slot, a one-entry valid/ready holding register.
  - Ports: clk, reset, load, load_data, pop, valid, data, free.
  - Instantiated N times with a generate loop.
- The top level holds:
  - Select decode (a one-hot load vector gated by accept).
  - in_ready mux.
  - Drop counter and pulse.

Test Plan:
- Reset, then in_sel=2, in_data=8'hA5, in_valid=1 for one cycle, all out_ready=0 -> next cycle out_valid=5'b00100, out_data[2]=8'hA5. A second beat to ch2 sees in_ready=0 and is held; setting out_ready[2]=1 accepts it (in_ready=1 same cycle) and out_data[2] updates the following cycle with out_valid[2] still 1.
- Stream sel=0,1,2,3,4 with data 8'h10..8'h14, all out_ready=1 -> one beat per cycle, each channel valid for exactly one cycle, correct data, in_ready continuously 1.
- Ch1 blocked (out_ready[1]=0, holding 8'h55), then beats to ch3 with out_ready[3]=1 -> ch3 accepted every cycle; ch1 data/valid stable throughout.
- in_sel=5, 6, 7 with in_valid=1 -> in_ready=1, out_valid unchanged, drop_cnt 0->3, drop_pulse high for 3 cycles then low. 260 consecutive drops -> drop_cnt saturates at 8'hFF.
- Load ch4 = 8'hC3, then assert reset asynchronously mid-cycle -> out_valid=0, out_data=0, drop_cnt=0 immediately, without waiting for a clock edge. After release, a fresh beat to ch4 behaves normally.
- in_valid=0 with in_sel toggling and random in_data -> no channel loads, drop_cnt unchanged.
